// File: rtl/onehot_step_decoder_if.sv
// Command/status bundle for the one-hot step decoder.
// The master side issues clear/load/step commands and observes the
// registered one-hot position; the slave side is the decoder itself.
interface onehot_step_decoder_if #(
    parameter int SEL_W = 4
);
    localparam int OUT_W = 1 << SEL_W;

    logic             sync_clr;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic             step;
    logic [SEL_W-1:0] last;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] index;
    logic             wrapped;

    modport master (
        output sync_clr,
        output load,
        output sel,
        output step,
        output last,
        input  out,
        input  index,
        input  wrapped
    );

    modport slave (
        input  sync_clr,
        input  load,
        input  sel,
        input  step,
        input  last,
        output out,
        output index,
        output wrapped
    );
endinterface

// File: rtl/onehot_step_decoder.sv
// Registered binary-to-one-hot decoder with a built-in step counter.
// Serves both as a register-select decoder (load a binary index) and as a
// control-step generator T0..Tn that wraps after a runtime limit.
// The one-hot vector is registered next to its binary index, so the
// enables seen downstream are glitch-free and always agree with index.
module onehot_step_decoder #(
    parameter int SEL_W     = 4,
    parameter int RESET_IDX = 0
) (
    input  logic                  clock,
    input  logic                  clear,
    onehot_step_decoder_if.slave  bus
);
    localparam int               OUT_W     = 1 << SEL_W;
    localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(RESET_IDX);
    localparam logic [OUT_W-1:0] RESET_OUT = OUT_W'(1) << RESET_IDX;

    logic [SEL_W-1:0] index_q;
    logic [SEL_W-1:0] index_d;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;
    logic             wrapped_q;
    logic             wrapped_d;
    logic             atLimit;

    // A position at or beyond the limit wraps on the next step, which also
    // covers indices loaded past the limit; overflow is never relied upon.
    assign atLimit = (index_q >= bus.last);

    // Next position, priority sync_clr > load > step > hold; the one-hot
    // vector is decoded from the next index so both registers move together.
    always_comb begin
        index_d   = index_q;
        wrapped_d = 1'b0;
        out_d     = '0;
        if (bus.sync_clr) begin
            index_d = RESET_SEL;
        end else if (bus.load) begin
            index_d = bus.sel;
        end else if (bus.step) begin
            if (atLimit) begin
                index_d   = '0;
                wrapped_d = 1'b1;
            end else begin
                index_d = index_q + SEL_W'(1);
            end
        end
        out_d[index_d] = 1'b1;
    end

    // Position, one-hot vector and wrap pulse registers; clear forces the
    // reset position immediately so out is never all-zero.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            index_q   <= RESET_SEL;
            out_q     <= RESET_OUT;
            wrapped_q <= 1'b0;
        end else begin
            index_q   <= index_d;
            out_q     <= out_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.index   = index_q;
    assign bus.out     = out_q;
    assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_onehot_step_decoder.sv
// Self-checking bench for onehot_step_decoder.
// Two instances run side by side from the same commands: one with the
// default reset position 0 and one with reset position 3. Expected
// results are pushed to a scoreboard queue when a command is driven and
// popped after the clock edge that should produce them.
module tb_onehot_step_decoder;
    localparam int SEL_W = 4;
    localparam int OUT_W = 1 << SEL_W;

    typedef struct {
        string            tag;
        logic [SEL_W-1:0] idx0;
        logic             w0;
        logic [SEL_W-1:0] idx1;
        logic             w1;
    } expect_t;

    logic clock;
    logic clear;
    int   checks;
    int   failures;

    int   mIdx[2];
    logic mWrap[2];
    expect_t scoreboard[$];

    onehot_step_decoder_if #(.SEL_W(SEL_W)) busA ();
    onehot_step_decoder_if #(.SEL_W(SEL_W)) busB ();

    onehot_step_decoder #(.SEL_W(SEL_W), .RESET_IDX(0)) dutA (
        .clock (clock),
        .clear (clear),
        .bus   (busA.slave)
    );

    onehot_step_decoder #(.SEL_W(SEL_W), .RESET_IDX(3)) dutB (
        .clock (clock),
        .clear (clear),
        .bus   (busB.slave)
    );

    // Both instances receive identical commands.
    assign busB.sync_clr = busA.sync_clr;
    assign busB.load     = busA.load;
    assign busB.sel      = busA.sel;
    assign busB.step     = busA.step;
    assign busB.last     = busA.last;

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int resetIdx(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic checkDut(input string tag, input logic [SEL_W-1:0] eIdx0, input logic eW0,
                            input logic [SEL_W-1:0] eIdx1, input logic eW1);
        logic [OUT_W-1:0] eOut0;
        logic [OUT_W-1:0] eOut1;
        eOut0 = OUT_W'(1) << eIdx0;
        eOut1 = OUT_W'(1) << eIdx1;
        checkOutput({tag, "_A_out"},     32'(busA.out),     32'(eOut0));
        checkOutput({tag, "_A_index"},   32'(busA.index),   32'(eIdx0));
        checkOutput({tag, "_A_wrapped"}, 32'(busA.wrapped), 32'(eW0));
        checkOutput({tag, "_A_onehot"},  32'($countones(busA.out)), 32'd1);
        checkOutput({tag, "_B_out"},     32'(busB.out),     32'(eOut1));
        checkOutput({tag, "_B_index"},   32'(busB.index),   32'(eIdx1));
        checkOutput({tag, "_B_wrapped"}, 32'(busB.wrapped), 32'(eW1));
        checkOutput({tag, "_B_onehot"},  32'($countones(busB.out)), 32'd1);
    endtask

    // Compare both DUTs against the current model state, no edge involved.
    task automatic checkNow(input string tag);
        checkDut(tag, SEL_W'(mIdx[0]), mWrap[0], SEL_W'(mIdx[1]), mWrap[1]);
    endtask

    // Drive one command, advance the model, queue the expectation, and
    // compare it against the DUT just after the edge.
    task automatic applyStimulus(input logic sc, input logic ld, input int s,
                                 input logic st, input int lst, input string tag);
        expect_t e;
        @(negedge clock);
        busA.sync_clr = sc;
        busA.load     = ld;
        busA.sel      = SEL_W'(s);
        busA.step     = st;
        busA.last     = SEL_W'(lst);
        for (int d = 0; d < 2; d++) begin
            mWrap[d] = 1'b0;
            if (sc) begin
                mIdx[d] = resetIdx(d);
            end else if (ld) begin
                mIdx[d] = s;
            end else if (st) begin
                if (mIdx[d] >= lst) begin
                    mIdx[d]  = 0;
                    mWrap[d] = 1'b1;
                end else begin
                    mIdx[d] = mIdx[d] + 1;
                end
            end
        end
        e.tag  = tag;
        e.idx0 = SEL_W'(mIdx[0]);
        e.w0   = mWrap[0];
        e.idx1 = SEL_W'(mIdx[1]);
        e.w1   = mWrap[1];
        scoreboard.push_back(e);
        @(posedge clock);
        #1;
        if (scoreboard.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 32'd0, 32'd1);
        end else begin
            e = scoreboard.pop_front();
            checkDut(e.tag, e.idx0, e.w0, e.idx1, e.w1);
        end
    endtask

    // Assert clear between edges, check the reset values appear at once,
    // release before the next edge and check they hold through it.
    task automatic pulseClear(input string tag);
        @(negedge clock);
        busA.sync_clr = 1'b0;
        busA.load     = 1'b0;
        busA.step     = 1'b0;
        clear = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mIdx[d]  = resetIdx(d);
            mWrap[d] = 1'b0;
        end
        #1;
        checkNow({tag, "_async"});
        #2;
        clear = 1'b0;
        @(posedge clock);
        #1;
        checkNow({tag, "_hold"});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear    = 1'b1;
        busA.sync_clr = 1'b0;
        busA.load     = 1'b0;
        busA.sel      = '0;
        busA.step     = 1'b0;
        busA.last     = '0;
        for (int d = 0; d < 2; d++) begin
            mIdx[d]  = resetIdx(d);
            mWrap[d] = 1'b0;
        end

        // Reset held across edges, then released.
        #12;
        checkNow("reset");
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        #1;
        checkNow("resetRelease");
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, "idle");

        // Decode sweep over every select value.
        for (int i = 0; i < OUT_W; i++) begin
            applyStimulus(1'b0, 1'b1, i, 1'b0, 0, $sformatf("sweep%0d", i));
        end

        // Mid-cycle reset from a non-reset position.
        applyStimulus(1'b0, 1'b1, 5, 1'b0, 0, "preClear");
        pulseClear("clear1");

        // Step and wrap with limit 2.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b1, 2, $sformatf("stepL2_%0d", i));
        end

        // Load past the limit, then step wraps, then steps normally.
        applyStimulus(1'b0, 1'b1, 9, 1'b0, 3, "loadOOR");
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 3, "oorWrap");
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 3, "oorStep");

        // Priority: load beats step, sync_clr beats load.
        applyStimulus(1'b0, 1'b1, 5, 1'b0, 15, "prioLoad5");
        applyStimulus(1'b0, 1'b1, 12, 1'b1, 15, "prioLoadStep");
        applyStimulus(1'b1, 1'b1, 7, 1'b1, 15, "prioSyncClr");

        // Limit 0: every step stays at 0 and pulses wrapped.
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 0, "last0_a");
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 0, "last0_b");
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, "last0_hold");

        // Full-range natural wrap 15 -> 0.
        applyStimulus(1'b0, 1'b1, 14, 1'b0, 15, "full14");
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 15, "full15");
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 15, "fullWrap");

        // Mid-run reset while stepping at index 10, then resume stepping.
        applyStimulus(1'b0, 1'b1, 9, 1'b0, 15, "midLoad9");
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 15, "midStep10");
        pulseClear("clearMid");
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 15, "midResume");

        // Random command mix.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, OUT_W - 1)), ($urandom_range(0, 1) == 1),
                          int'($urandom_range(0, OUT_W - 1)), $sformatf("rand%0d", i));
        end

        checkOutput("sbDrained", 32'(scoreboard.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
